cmd_arbiter: RTL and testbench
==============================

Name: cmd_arbiter

Overview:
Merges the two user-input sources, the PS/2 keyboard decoder and the PS/2 mouse interface, into one ordered command stream for the active game core.
- Detects rising edges on the input levels.
- Holds one pending command per source.
- Arbitrates between the sources round-robin.
- Buffers granted commands in a small FIFO, drained by the core through a valid/ready handshake.
- Sits between the input decoders and game_core / ms_top, which gain a single cmd port plus cmd_ready so they can stall input during move animation or level load.

Parameters:
FIFO_DEPTH, 4, number of command FIFO entries; must be a power of two, at least 2.
DROP_W, 8, width of the saturating dropped-command counter.

Ports:
clk  in  1  system clock (sys_clk domain).
reset  in  1  synchronous, active-high reset.
flush  in  1  synchronous clear of slots and FIFO, driven by switch_reset on a game switch.
key_in  in  7  keyboard levels {left,up,down,right,retry,retract,next}, bit 6 = left.
mouse_left  in  1  mouse left-button level.
mouse_right  in  1  mouse right-button level.
mouse_retract  in  1  mouse retract-button level.
mouse_retry  in  1  mouse retry-button level.
game_area  in  1  pointer is inside the 8x8 board.
cursor  in  6  board cell under the pointer.
cmd_ready  in  1  core accepts a command this cycle.
cmd_valid  out  1  FIFO head is valid.
cmd_code  out  4  FIFO head command code.
cmd_cursor  out  6  FIFO head cursor; 0 for keyboard commands.
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
drop_cnt  out  DROP_W  saturating count of discarded commands.

Behaviour:
- Reset values: all outputs 0. Slots are empty. Round-robin pointer favours the keyboard first. Edge-detect history registers are set to all ones, so inputs held through reset do not fire.
- Edge detection: rise = in & ~prev. prev updates every cycle, including during flush.
- Keyboard slot: on any key rise, load the highest-priority code. Priority order is retry(5) > retract(6) > next(7) > left(1) > up(2) > down(3) > right(4). Other simultaneous rises are discarded and each one increments drop_cnt.
- Mouse slot: a left or right rise counts only if game_area=1 in the same cycle; otherwise it is ignored and not counted as a drop.
  - Mouse priority is retry(5) > retract(6) > left(8) > right(9).
  - cursor is captured at load time for codes 8 and 9; cmd_cursor is 0 for all other codes.
- Arbitration (every cycle):
  - Grant happens only if the FIFO is not full.
  - If one slot is pending, grant it. If both are pending, grant the source not granted last, then update the pointer.
  - The granted slot is written to the FIFO and cleared.
- Slot conflict: a new edge arriving at a pending slot is dropped (drop_cnt+1) unless that slot is granted in the same cycle. In that case the new command loads into the freed slot.
- FIFO: first-word fall-through. cmd_valid = (fifo_count != 0). A pop happens when cmd_valid & cmd_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - When full, there is no grant and slots stay pending (back-pressure).
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: rise visible in cycle 0, slot loaded in cycle 1, grant/push at the end of cycle 1, cmd_valid=1 in cycle 2. Minimum latency is 2 cycles.
- drop_cnt saturates at 2^DROP_W-1. It is cleared only by reset, not by flush.
- Flush: in the next cycle the slots are empty, the FIFO is empty, and cmd_valid=0. Edges arriving in the flush cycle are discarded and not counted. reset has priority over flush.
- cmd_code and cmd_cursor are don't-care when cmd_valid=0, but are driven from the head entry with no combinational path from the inputs.

Decomposition:
- Package cmd_pkg holds the CMD_* 4-bit codes (NONE=0, LEFT=1, UP=2, DOWN=3, RIGHT=4, RETRY=5, RETRACT=6, NEXT=7, M_LEFT=8, M_RIGHT=9) and a struct/localparam for the 10-bit entry {code, cursor}.
- Sub-module cmd_fifo is a synchronous FWFT FIFO with push, pop, flush and count, parameterised by depth and width.
- Edge detection, slots and round-robin stay in cmd_arbiter.

Test Plan:
- Reset, then a single key_in left rise with cmd_ready=1 -> cmd_valid=1 exactly 2 cycles later with cmd_code=1, cmd_cursor=0; popped next cycle, fifo_count returns to 0.
- Same-cycle rises of key retry and mouse_left (game_area=1, cursor=6'd37), cmd_ready=1 -> two commands in order: keyboard first (code 5), then mouse (code 8, cursor 37). A repeat of both rises -> mouse first.
- cmd_ready=0, five keyboard rises spaced 3 cycles apart (depth 4) -> fifo_count=4, 5th held in slot, drop_cnt=0. Sixth rise -> drop_cnt=1. Release cmd_ready -> 5 commands delivered in order.
- mouse_right rise with game_area=0 -> nothing queued, drop_cnt unchanged. Same with game_area=1 -> code 9 queued.
- Simultaneous up+down+right rises -> only code 2 queued, drop_cnt=2.
- FIFO holds 3 entries, flush pulse -> next cycle cmd_valid=0, fifo_count=0, drop_cnt retained. Key held high through reset -> no command after reset deasserts.

Source files
------------

// File: rtl/cmd_pkg.sv
// Command codes and the queued entry layout shared by the arbiter and its FIFO.
package cmd_pkg;

  localparam logic [3:0] CMD_NONE    = 4'd0;
  localparam logic [3:0] CMD_LEFT    = 4'd1;
  localparam logic [3:0] CMD_UP      = 4'd2;
  localparam logic [3:0] CMD_DOWN    = 4'd3;
  localparam logic [3:0] CMD_RIGHT   = 4'd4;
  localparam logic [3:0] CMD_RETRY   = 4'd5;
  localparam logic [3:0] CMD_RETRACT = 4'd6;
  localparam logic [3:0] CMD_NEXT    = 4'd7;
  localparam logic [3:0] CMD_M_LEFT  = 4'd8;
  localparam logic [3:0] CMD_M_RIGHT = 4'd9;

  localparam int ENTRY_W = 10;

  typedef struct packed {
    logic [3:0] code;
    logic [5:0] cursor;
  } cmd_entry_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and occupancy count.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && valid && !flush;

  // Head is masked when empty so the output is a clean zero after reset.
  assign head_data = valid ? mem[rd_ptr] : '0;

  // Pointers and count; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; data only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cmd_arbiter.sv
// Merges keyboard and mouse button edges into one ordered command stream.
module cmd_arbiter
  import cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [6:0]                    key_in,
  input  logic                          mouse_left,
  input  logic                          mouse_right,
  input  logic                          mouse_retract,
  input  logic                          mouse_retry,
  input  logic                          game_area,
  input  logic [5:0]                    cursor,
  input  logic                          cmd_ready,
  output logic                          cmd_valid,
  output logic [3:0]                    cmd_code,
  output logic [5:0]                    cmd_cursor,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [DROP_W-1:0]             drop_cnt
);

  // Keyboard bits: 6 left, 5 up, 4 down, 3 right, 2 retry, 1 retract, 0 next.
  function automatic logic [3:0] key_pick(input logic [6:0] r);
    if      (r[2]) return CMD_RETRY;
    else if (r[1]) return CMD_RETRACT;
    else if (r[0]) return CMD_NEXT;
    else if (r[6]) return CMD_LEFT;
    else if (r[5]) return CMD_UP;
    else if (r[4]) return CMD_DOWN;
    else if (r[3]) return CMD_RIGHT;
    else           return CMD_NONE;
  endfunction

  // Mouse bits: 3 retry, 2 retract, 1 left, 0 right.
  function automatic logic [3:0] mouse_pick(input logic [3:0] r);
    if      (r[3]) return CMD_RETRY;
    else if (r[2]) return CMD_RETRACT;
    else if (r[1]) return CMD_M_LEFT;
    else if (r[0]) return CMD_M_RIGHT;
    else           return CMD_NONE;
  endfunction

  function automatic logic [2:0] pop7(input logic [6:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 7; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                input logic [3:0] b);
    logic [DROP_W:0] s;
    s = {1'b0, a} + {{(DROP_W-3){1'b0}}, b};
    return s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
  endfunction

  logic [3:0]  mouse_lvl;
  logic [6:0]  key_prev_p0;
  logic [3:0]  mouse_prev_p0;
  logic [6:0]  key_rise;
  logic [3:0]  mouse_rise;

  logic        kbd_pend_p1;
  logic [3:0]  kbd_code_p1;
  logic        mouse_pend_p1;
  cmd_entry_t  mouse_entry_p1;
  logic        prefer_mouse_p1;

  logic        grant_kbd;
  logic        grant_mouse;
  logic        rr_flip;
  logic        kbd_blocked;
  logic        mouse_blocked;
  logic        kbd_load;
  logic        mouse_load;
  logic [3:0]  kbd_next_code;
  logic [3:0]  mouse_next_code;
  logic [2:0]  kbd_drops;
  logic [2:0]  mouse_drops;
  logic [3:0]  drops;

  logic        fifo_full;
  cmd_entry_t  push_entry;
  cmd_entry_t  head_entry;

  assign mouse_lvl = {mouse_retry, mouse_retract, mouse_left, mouse_right};

  // ---- stage p0: edge detection against last cycle's levels ----
  assign key_rise   = key_in & ~key_prev_p0;
  assign mouse_rise = {mouse_lvl[3:2] & ~mouse_prev_p0[3:2],
                       mouse_lvl[1:0] & ~mouse_prev_p0[1:0] & {2{game_area}}};

  // History starts at all ones so levels held through reset never fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_prev_p0   <= '1;
      mouse_prev_p0 <= '1;
    end else begin
      key_prev_p0   <= key_in;
      mouse_prev_p0 <= mouse_lvl;
    end
  end

  // Round-robin grant from the pending slots; the pointer moves only on contention.
  always_comb begin
    grant_kbd   = 1'b0;
    grant_mouse = 1'b0;
    rr_flip     = 1'b0;
    if (!flush && !fifo_full) begin
      if (kbd_pend_p1 && mouse_pend_p1) begin
        rr_flip = 1'b1;
        if (prefer_mouse_p1) grant_mouse = 1'b1;
        else                 grant_kbd   = 1'b1;
      end else if (kbd_pend_p1) begin
        grant_kbd = 1'b1;
      end else if (mouse_pend_p1) begin
        grant_mouse = 1'b1;
      end
    end
  end

  // Slot loading and drop accounting; a slot freed by this cycle's grant can reload.
  always_comb begin
    kbd_next_code   = key_pick(key_rise);
    mouse_next_code = mouse_pick(mouse_rise);
    kbd_blocked     = kbd_pend_p1 && !grant_kbd;
    mouse_blocked   = mouse_pend_p1 && !grant_mouse;
    kbd_load        = !flush && (|key_rise) && !kbd_blocked;
    mouse_load      = !flush && (|mouse_rise) && !mouse_blocked;
    kbd_drops       = '0;
    mouse_drops     = '0;
    if (|key_rise)
      kbd_drops = kbd_blocked ? pop7(key_rise) : pop7(key_rise) - 3'd1;
    if (|mouse_rise)
      mouse_drops = mouse_blocked ? pop7({3'b000, mouse_rise})
                                  : pop7({3'b000, mouse_rise}) - 3'd1;
    drops = flush ? 4'd0 : ({1'b0, kbd_drops} + {1'b0, mouse_drops});
  end

  // ---- stage p1: pending slots, round-robin pointer, drop counter ----
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      kbd_pend_p1   <= 1'b0;
      mouse_pend_p1 <= 1'b0;
    end else begin
      if (kbd_load)       kbd_pend_p1 <= 1'b1;
      else if (grant_kbd) kbd_pend_p1 <= 1'b0;
      if (mouse_load)       mouse_pend_p1 <= 1'b1;
      else if (grant_mouse) mouse_pend_p1 <= 1'b0;
    end
  end

  // Slot payloads; cursor is kept only for board clicks.
  always_ff @(posedge clk) begin
    if (kbd_load) kbd_code_p1 <= kbd_next_code;
    if (mouse_load) begin
      mouse_entry_p1.code   <= mouse_next_code;
      mouse_entry_p1.cursor <= (mouse_next_code == CMD_M_LEFT ||
                                mouse_next_code == CMD_M_RIGHT) ? cursor : 6'd0;
    end
  end

  // Pointer and saturating drop counter; flush leaves the counter alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      prefer_mouse_p1 <= 1'b0;
      drop_cnt        <= '0;
    end else begin
      if (rr_flip) prefer_mouse_p1 <= ~prefer_mouse_p1;
      drop_cnt <= sat_add(drop_cnt, drops);
    end
  end

  // ---- stage p2: command FIFO towards the core ----
  assign push_entry = grant_kbd ? cmd_entry_t'({kbd_code_p1, 6'd0}) : mouse_entry_p1;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (grant_kbd || grant_mouse),
    .push_data (push_entry),
    .pop       (cmd_ready),
    .head_data (head_entry),
    .valid     (cmd_valid),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign cmd_code   = head_entry.code;
  assign cmd_cursor = head_entry.cursor;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed bench for cmd_arbiter with hand-computed expectations.
module tb_cmd_arbiter;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [6:0] key_in;
  logic       mouse_left;
  logic       mouse_right;
  logic       mouse_retract;
  logic       mouse_retry;
  logic       game_area;
  logic [5:0] cursor;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [3:0] cmd_code;
  logic [5:0] cmd_cursor;
  logic [2:0] fifo_count;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  cmd_arbiter #(
    .FIFO_DEPTH (4),
    .DROP_W     (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .key_in        (key_in),
    .mouse_left    (mouse_left),
    .mouse_right   (mouse_right),
    .mouse_retract (mouse_retract),
    .mouse_retry   (mouse_retry),
    .game_area     (game_area),
    .cursor        (cursor),
    .cmd_ready     (cmd_ready),
    .cmd_valid     (cmd_valid),
    .cmd_code      (cmd_code),
    .cmd_cursor    (cmd_cursor),
    .fifo_count    (fifo_count),
    .drop_cnt      (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One-cycle key pulse followed by two idle cycles.
  task automatic pulse_key(input logic [6:0] v);
    key_in = v;
    tick();
    key_in = 7'd0;
    tick();
    tick();
  endtask

  logic [6:0] fill_keys [6];
  logic [3:0] fill_codes [5];

  initial begin
    fill_keys[0] = 7'b1000000;  // left
    fill_keys[1] = 7'b0100000;  // up
    fill_keys[2] = 7'b0010000;  // down
    fill_keys[3] = 7'b0001000;  // right
    fill_keys[4] = 7'b0000001;  // next
    fill_keys[5] = 7'b0000010;  // retract
    fill_codes[0] = 4'd1;
    fill_codes[1] = 4'd2;
    fill_codes[2] = 4'd3;
    fill_codes[3] = 4'd4;
    fill_codes[4] = 4'd7;

    reset = 1'b1; flush = 1'b0; key_in = 7'd0;
    mouse_left = 1'b0; mouse_right = 1'b0; mouse_retract = 1'b0; mouse_retry = 1'b0;
    game_area = 1'b0; cursor = 6'd0; cmd_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(cmd_valid), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_code", 32'(cmd_code), 0);
    reset = 1'b0;
    tick();

    // single left key, 2-cycle latency then pop
    cmd_ready = 1'b1;
    key_in = 7'b1000000;
    tick();
    check("lat_valid_c1", 32'(cmd_valid), 0);
    key_in = 7'd0;
    tick();
    check("lat_valid_c2", 32'(cmd_valid), 1);
    check("lat_code", 32'(cmd_code), 1);
    check("lat_cursor", 32'(cmd_cursor), 0);
    tick();
    check("lat_pop_count", 32'(fifo_count), 0);
    check("lat_pop_valid", 32'(cmd_valid), 0);

    // contention: keyboard first
    key_in = 7'b0000100; mouse_left = 1'b1; game_area = 1'b1; cursor = 6'd37;
    tick();
    key_in = 7'd0; mouse_left = 1'b0;
    tick();
    check("rr1_first_code", 32'(cmd_code), 5);
    check("rr1_first_cur", 32'(cmd_cursor), 0);
    tick();
    check("rr1_second_code", 32'(cmd_code), 8);
    check("rr1_second_cur", 32'(cmd_cursor), 37);
    tick();
    check("rr1_empty", 32'(fifo_count), 0);

    // contention again: mouse first
    key_in = 7'b0000100; mouse_left = 1'b1;
    tick();
    key_in = 7'd0; mouse_left = 1'b0;
    tick();
    check("rr2_first_code", 32'(cmd_code), 8);
    check("rr2_first_cur", 32'(cmd_cursor), 37);
    tick();
    check("rr2_second_code", 32'(cmd_code), 5);
    tick();
    check("rr2_empty", 32'(fifo_count), 0);
    game_area = 1'b0;

    // back-pressure: fill FIFO, fifth held in slot, sixth dropped
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) pulse_key(fill_keys[i]);
    check("full_count", 32'(fifo_count), 4);
    check("full_drop0", 32'(drop_cnt), 0);
    pulse_key(fill_keys[5]);
    check("full_drop1", 32'(drop_cnt), 1);
    check("full_count2", 32'(fifo_count), 4);
    cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("drain_code%0d", i), 32'(cmd_code), 32'(fill_codes[i]));
      tick();
    end
    check("drain_empty", 32'(fifo_count), 0);

    // mouse_right outside the board is ignored, inside it queues code 9
    mouse_right = 1'b1;
    tick();
    tick();
    tick();
    check("oob_count", 32'(fifo_count), 0);
    check("oob_drop", 32'(drop_cnt), 1);
    mouse_right = 1'b0;
    tick();
    game_area = 1'b1; cursor = 6'd5; mouse_right = 1'b1;
    tick();
    mouse_right = 1'b0;
    tick();
    check("mr_valid", 32'(cmd_valid), 1);
    check("mr_code", 32'(cmd_code), 9);
    check("mr_cursor", 32'(cmd_cursor), 5);
    tick();
    check("mr_empty", 32'(fifo_count), 0);
    game_area = 1'b0;

    // simultaneous up+down+right: up wins, two drops
    key_in = 7'b0111000;
    tick();
    key_in = 7'd0;
    tick();
    check("multi_code", 32'(cmd_code), 2);
    check("multi_drop", 32'(drop_cnt), 3);
    tick();
    check("multi_empty", 32'(fifo_count), 0);
    tick();
    check("multi_single", 32'(fifo_count), 0);

    // flush with three queued entries; edge in flush cycle discarded
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) pulse_key(fill_keys[i]);
    check("pre_flush_count", 32'(fifo_count), 3);
    flush = 1'b1;
    key_in = 7'b1000000;
    tick();
    flush = 1'b0;
    check("flush_valid", 32'(cmd_valid), 0);
    check("flush_count", 32'(fifo_count), 0);
    check("flush_drop", 32'(drop_cnt), 3);
    key_in = 7'd0;
    tick();
    tick();
    check("flush_edge_gone", 32'(fifo_count), 0);
    check("flush_drop_kept", 32'(drop_cnt), 3);

    // key held through reset never fires
    key_in = 7'b0000100;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    check("held_count", 32'(fifo_count), 0);
    check("held_valid", 32'(cmd_valid), 0);
    check("held_drop", 32'(drop_cnt), 0);
    key_in = 7'd0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
